// File: rtl/riot_ng_if.sv
// riot_ng_if -- host bus of the RIOT_NG block.
//   CS1, CS2_N : chip selects (selected = CS1 & ~CS2_N)
//   RS_N       : 0 = RAM space, 1 = register space
//   R_W        : 1 = read, 0 = write
//   A          : 7-bit address
//   D_I        : write data from the host
//   D_O        : registered read data from the device
// The master modport is the host side, the slave modport is the device side.
interface riot_ng_if;
  logic       CS1;
  logic       CS2_N;
  logic       RS_N;
  logic       R_W;
  logic [6:0] A;
  logic [7:0] D_I;
  logic [7:0] D_O;

  modport master (
    output CS1, CS2_N, RS_N, R_W, A, D_I,
    input  D_O
  );

  modport slave (
    input  CS1, CS2_N, RS_N, R_W, A, D_I,
    output D_O
  );
endinterface

// File: rtl/riot_ng.sv
// riot_ng -- RAM / parallel I/O / interval timer peripheral.
// All state changes on the falling edge of PHI2; RES_N clears registers
// asynchronously (the RAM contents survive reset).
// Ports:
//   PHI2        : clock, active on its falling edge
//   RES_N       : asynchronous active-low reset
//   bus         : host bus (riot_ng_if.slave): selects, RS_N, R_W, A, D_I, D_O
//   P_I         : port pins, port p on bits [8p+7:8p]
//   P_O         : output register masked by the data-direction register
//   DDR_O       : registered image of the data-direction registers
//   IRQ_N       : active-low interrupt, OR of enabled timer and edge flags
// Register map (RS_N = 1):
//   A[6]=0              : port p=A[2:1]; A[0]=0 data (rd pins / wr OR), A[0]=1 DDR
//   A[6:5]=10           : timer t=A[4:3], sub=A[2:0]
//                         sub0..3 load V*1/8/64/1024, sub4 control, sub5 count read
//   A=0x60+p            : edge control of port p (bit0 enable, bit1 1=rising)
//   A=0x7F              : status {timer flags[3:0], edge flags[3:0]}
module riot_ng #(
  parameter int N_PORTS  = 2,
  parameter int N_TIMERS = 1,
  parameter int RAM_AW   = 7
) (
  input  logic                 PHI2,
  input  logic                 RES_N,
  riot_ng_if.slave             bus,
  input  logic [8*N_PORTS-1:0] P_I,
  output logic [8*N_PORTS-1:0] P_O,
  output logic [8*N_PORTS-1:0] DDR_O,
  output logic                 IRQ_N
);

  // ---------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------
  logic sel, rd, wr;
  logic ram_hit, port_hit, tim_hit, edge_hit, status_hit;

  assign sel        = bus.CS1 & ~bus.CS2_N;
  assign rd         = sel & bus.R_W;
  assign wr         = sel & ~bus.R_W;
  assign ram_hit    = ~bus.RS_N;
  assign port_hit   = bus.RS_N & ~bus.A[6];
  assign tim_hit    = bus.RS_N & bus.A[6] & ~bus.A[5];
  assign edge_hit   = bus.RS_N & bus.A[6] & bus.A[5] & (bus.A[4:2] == 3'b000);
  assign status_hit = bus.RS_N & (bus.A == 7'h7F);

  // Status read clears the edge flags (a same-cycle edge still wins).
  logic status_rd;
  assign status_rd = rd & status_hit;

  // Prescale select -> shift amount (P = 1, 8, 64, 1024).
  function automatic logic [3:0] shamt(input logic [1:0] s);
    case (s)
      2'd0:    shamt = 4'd0;
      2'd1:    shamt = 4'd3;
      2'd2:    shamt = 4'd6;
      default: shamt = 4'd10;
    endcase
  endfunction

  // ---------------------------------------------------------------------
  // RAM: no reset, contents survive RES_N. Upper address bits alias.
  // ---------------------------------------------------------------------
  logic [7:0] ram_q [2**RAM_AW];
  logic [7:0] ram_rdata;

  always_ff @(negedge PHI2) begin
    if (wr & ram_hit)
      ram_q[bus.A[RAM_AW-1:0]] <= bus.D_I;
  end

  assign ram_rdata = ram_q[bus.A[RAM_AW-1:0]];

  // ---------------------------------------------------------------------
  // I/O ports with edge detection on the top pin of each port
  // ---------------------------------------------------------------------
  logic [7:0]         port_rd [N_PORTS];
  logic [7:0]         edge_rd [N_PORTS];
  logic [N_PORTS-1:0] eflag;
  logic [N_PORTS-1:0] een;

  genvar gi;
  generate
    for (gi = 0; gi < N_PORTS; gi++) begin : g_port
      logic [7:0] or_q, or_d;
      logic [7:0] ddr_q, ddr_d;
      logic [7:0] po_q, ddro_q;
      logic [1:0] ectl_q;
      logic       prev_q;
      logic       eflag_q;
      logic       this_port, this_edge, pin, edge_seen;

      assign this_port = port_hit & (bus.A[2:1] == 2'(gi));
      assign this_edge = edge_hit & (bus.A[1:0] == 2'(gi));

      assign or_d  = (wr & this_port & ~bus.A[0]) ? bus.D_I : or_q;
      assign ddr_d = (wr & this_port &  bus.A[0]) ? bus.D_I : ddr_q;

      assign pin = P_I[8*gi+7];
      // prev_q holds the pin as seen at the previous falling edge.
      assign edge_seen = ectl_q[1] ? (pin & ~prev_q) : (~pin & prev_q);

      always_ff @(negedge PHI2 or negedge RES_N) begin
        if (!RES_N) begin
          or_q    <= '0;
          ddr_q   <= '0;
          po_q    <= '0;
          ddro_q  <= '0;
          ectl_q  <= '0;
          prev_q  <= 1'b0;
          eflag_q <= 1'b0;
        end else begin
          or_q   <= or_d;
          ddr_q  <= ddr_d;
          // Pins track the new register values on the same edge as the write.
          po_q   <= or_d & ddr_d;
          ddro_q <= ddr_d;
          prev_q <= pin;
          if (wr & this_edge)
            ectl_q <= bus.D_I[1:0];
          if (edge_seen)
            eflag_q <= 1'b1;
          else if (status_rd)
            eflag_q <= 1'b0;
        end
      end

      assign P_O[8*gi +: 8]   = po_q;
      assign DDR_O[8*gi +: 8] = ddro_q;
      assign port_rd[gi]      = bus.A[0] ? ddr_q : P_I[8*gi +: 8];
      assign edge_rd[gi]      = {6'b0, ectl_q};
      assign eflag[gi]        = eflag_q;
      assign een[gi]          = ectl_q[0];
    end
  endgenerate

  // ---------------------------------------------------------------------
  // Interval timers
  // ---------------------------------------------------------------------
  logic [7:0]          tim_rd [N_TIMERS];
  logic [N_TIMERS-1:0] tflag;
  logic [N_TIMERS-1:0] tien;

  generate
    for (gi = 0; gi < N_TIMERS; gi++) begin : g_timer
      logic [18:0] cnt_q;
      logic [1:0]  psel_q;
      logic [7:0]  v_q;
      logic        oneshot_q;   // set after an underflow without auto-reload
      logic        flag_q;
      logic [1:0]  ctrl_q;      // bit0 IRQ enable, bit1 auto-reload
      logic        this_tim, wr_load, wr_ctrl, cnt_rd, underflow;
      logic [18:0] load_val, reload_val, cnt_scaled;

      assign this_tim   = tim_hit & (bus.A[4:3] == 2'(gi));
      assign wr_load    = wr & this_tim & ~bus.A[2];
      assign wr_ctrl    = wr & this_tim & (bus.A[2:0] == 3'd4);
      assign cnt_rd     = rd & this_tim & (bus.A[2:0] == 3'd5);
      // The counter "passes 0" on the cycle it is decremented from zero.
      assign underflow  = (cnt_q == 19'd0);
      assign load_val   = 19'(bus.D_I) << shamt(bus.A[1:0]);
      assign reload_val = 19'(v_q) << shamt(psel_q);
      assign cnt_scaled = cnt_q >> shamt(psel_q);

      always_ff @(negedge PHI2 or negedge RES_N) begin
        if (!RES_N) begin
          cnt_q     <= '0;
          psel_q    <= '0;
          v_q       <= '0;
          oneshot_q <= 1'b0;
          flag_q    <= 1'b0;
          ctrl_q    <= '0;
        end else begin
          if (wr_load) begin
            // A load beats an underflow landing on the same edge.
            cnt_q     <= load_val;
            psel_q    <= bus.A[1:0];
            v_q       <= bus.D_I;
            oneshot_q <= 1'b0;
            flag_q    <= 1'b0;
          end else if (underflow) begin
            // Set beats a same-edge clear-on-read.
            flag_q <= 1'b1;
            if (ctrl_q[1]) begin
              cnt_q     <= reload_val;
              oneshot_q <= 1'b0;
            end else begin
              cnt_q     <= 19'h7FFFF;
              oneshot_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q - 19'd1;
            if (cnt_rd)
              flag_q <= 1'b0;
          end
          if (wr_ctrl)
            ctrl_q <= bus.D_I[1:0];
        end
      end

      always_comb begin
        tim_rd[gi] = 8'h00;
        if (bus.A[2:0] == 3'd4)
          tim_rd[gi] = {6'b0, ctrl_q};
        else if (bus.A[2:0] == 3'd5)
          tim_rd[gi] = oneshot_q ? cnt_q[7:0] : cnt_scaled[7:0];
      end

      assign tflag[gi] = flag_q;
      assign tien[gi]  = ctrl_q[0];
    end
  endgenerate

  // ---------------------------------------------------------------------
  // Status, interrupt and read-data path
  // ---------------------------------------------------------------------
  logic [3:0] tflag4, eflag4;

  always_comb begin
    tflag4                 = '0;
    tflag4[N_TIMERS-1:0]   = tflag;
    eflag4                 = '0;
    eflag4[N_PORTS-1:0]    = eflag;
  end

  assign IRQ_N = ~(|(tflag & tien) | |(eflag & een));

  logic [7:0] rdata;
  logic [7:0] d_o_q, d_o_d;

  always_comb begin
    rdata = 8'h00;
    if (ram_hit) begin
      rdata = ram_rdata;
    end else if (port_hit) begin
      for (int i = 0; i < N_PORTS; i++)
        if (bus.A[2:1] == 2'(i)) rdata = port_rd[i];
    end else if (tim_hit) begin
      for (int i = 0; i < N_TIMERS; i++)
        if (bus.A[4:3] == 2'(i)) rdata = tim_rd[i];
    end else if (edge_hit) begin
      for (int i = 0; i < N_PORTS; i++)
        if (bus.A[1:0] == 2'(i)) rdata = edge_rd[i];
    end else if (status_hit) begin
      rdata = {tflag4, eflag4};
    end
  end

  assign d_o_d = rd ? rdata : 8'h00;

  always_ff @(negedge PHI2 or negedge RES_N) begin
    if (!RES_N)
      d_o_q <= 8'h00;
    else
      d_o_q <= d_o_d;
  end

  assign bus.D_O = d_o_q;

endmodule

// File: tb/tb_riot_ng.sv
module tb_riot_ng;

  logic        PHI2 = 1'b0;
  logic        RES_N;
  logic [15:0] P_I;
  logic [15:0] P_O;
  logic [15:0] DDR_O;
  logic        IRQ_N;

  riot_ng_if bif();

  riot_ng #(.N_PORTS(2), .N_TIMERS(1), .RAM_AW(7)) dut (
    .PHI2  (PHI2),
    .RES_N (RES_N),
    .bus   (bif.slave),
    .P_I   (P_I),
    .P_O   (P_O),
    .DDR_O (DDR_O),
    .IRQ_N (IRQ_N)
  );

  always #5 PHI2 = ~PHI2;

  typedef struct {
    logic        cs;
    logic        rs;
    logic        rw;
    logic [6:0]  a;
    logic [7:0]  d;
    logic [15:0] pi;
    logic [7:0]  exp_do;
    logic [15:0] exp_po;
    logic [15:0] exp_ddr;
  } vec_t;

  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] exp_q[$];

  function automatic vec_t mk(input logic cs, input logic rs, input logic rw,
                              input logic [6:0] a, input logic [7:0] d,
                              input logic [15:0] pi, input logic [7:0] e_do,
                              input logic [15:0] e_po, input logic [15:0] e_ddr);
    vec_t v;
    v.cs = cs; v.rs = rs; v.rw = rw; v.a = a; v.d = d; v.pi = pi;
    v.exp_do = e_do; v.exp_po = e_po; v.exp_ddr = e_ddr;
    return v;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One bus cycle: drive, push expectation, take the falling edge, pop and compare.
  task automatic bus(input logic cs, input logic rs, input logic rw,
                     input logic [6:0] a, input logic [7:0] d, input logic [7:0] exp);
    logic [7:0] e;
    bif.CS1 = cs; bif.CS2_N = 1'b0; bif.RS_N = rs; bif.R_W = rw;
    bif.A = a; bif.D_I = d;
    exp_q.push_back(exp);
    @(negedge PHI2); #1;
    e = exp_q.pop_front();
    check($sformatf("d_o a=%h rs=%0d rw=%0d", a, rs, rw), {8'h00, bif.D_O}, {8'h00, e});
    $display("bus cs=%0d rs=%0d rw=%0d a=%h d=%h -> d_o=%h irq_n=%0d", cs, rs, rw, a, d, bif.D_O, IRQ_N);
  endtask

  task automatic idle(input int n);
    bif.CS1 = 1'b0; bif.R_W = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge PHI2); #1;
    end
  endtask

  task automatic chk_irq(input string name, input logic exp);
    check(name, {15'h0, IRQ_N}, {15'h0, exp});
  endtask

  vec_t tbl[23];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tbl[0]  = mk(1,0,0,7'h05,8'hA5,16'h0000,8'h00,16'h0000,16'h0000);
    tbl[1]  = mk(1,0,1,7'h05,8'h00,16'h0000,8'hA5,16'h0000,16'h0000);
    tbl[2]  = mk(1,0,0,7'h7F,8'h5A,16'h0000,8'h00,16'h0000,16'h0000);
    tbl[3]  = mk(1,0,1,7'h7F,8'h00,16'h0000,8'h5A,16'h0000,16'h0000);
    tbl[4]  = mk(1,0,1,7'h05,8'h00,16'h0000,8'hA5,16'h0000,16'h0000);
    tbl[5]  = mk(1,1,1,7'h7F,8'h00,16'h0000,8'h10,16'h0000,16'h0000);
    tbl[6]  = mk(1,1,0,7'h01,8'h0F,16'h0000,8'h00,16'h0000,16'h000F);
    tbl[7]  = mk(1,1,0,7'h00,8'hFF,16'h0000,8'h00,16'h000F,16'h000F);
    tbl[8]  = mk(1,1,1,7'h01,8'h00,16'h0000,8'h0F,16'h000F,16'h000F);
    tbl[9]  = mk(1,1,1,7'h00,8'h00,16'h003C,8'h3C,16'h000F,16'h000F);
    tbl[10] = mk(1,1,0,7'h03,8'hF0,16'h003C,8'h00,16'h000F,16'hF00F);
    tbl[11] = mk(1,1,0,7'h02,8'h55,16'h003C,8'h00,16'h500F,16'hF00F);
    tbl[12] = mk(1,1,1,7'h02,8'h00,16'h5A3C,8'h5A,16'h500F,16'hF00F);
    tbl[13] = mk(1,1,1,7'h03,8'h00,16'h5A3C,8'hF0,16'h500F,16'hF00F);
    tbl[14] = mk(1,1,0,7'h04,8'hFF,16'h5A3C,8'h00,16'h500F,16'hF00F);
    tbl[15] = mk(1,1,1,7'h04,8'h00,16'h5A3C,8'h00,16'h500F,16'hF00F);
    tbl[16] = mk(0,0,1,7'h05,8'h00,16'h5A3C,8'h00,16'h500F,16'hF00F);
    tbl[17] = mk(1,1,1,7'h4D,8'h00,16'h5A3C,8'h00,16'h500F,16'hF00F);
    tbl[18] = mk(1,1,1,7'h60,8'h00,16'h5A3C,8'h00,16'h500F,16'hF00F);
    tbl[19] = mk(1,1,1,7'h44,8'h00,16'h5A3C,8'h00,16'h500F,16'hF00F);
    tbl[20] = mk(1,1,0,7'h4C,8'h03,16'h5A3C,8'h00,16'h500F,16'hF00F);
    tbl[21] = mk(1,1,1,7'h44,8'h00,16'h5A3C,8'h00,16'h500F,16'hF00F);
    tbl[22] = mk(1,1,1,7'h7F,8'h00,16'h5A3C,8'h10,16'h500F,16'hF00F);

    // Reset state
    RES_N = 1'b0; P_I = 16'h0000;
    bif.CS1 = 1'b0; bif.CS2_N = 1'b0; bif.RS_N = 1'b0; bif.R_W = 1'b1;
    bif.A = 7'h00; bif.D_I = 8'h00;
    #3;
    check("rst d_o",   {8'h00, bif.D_O}, 16'h0000);
    check("rst p_o",   P_O,   16'h0000);
    check("rst ddr_o", DDR_O, 16'h0000);
    chk_irq("rst irq_n", 1'b1);
    @(negedge PHI2); @(negedge PHI2); #1;
    RES_N = 1'b1;

    // Table-driven register / RAM / port vectors
    for (int i = 0; i < 23; i++) begin
      P_I = tbl[i].pi;
      bus(tbl[i].cs, tbl[i].rs, tbl[i].rw, tbl[i].a, tbl[i].d, tbl[i].exp_do);
      check($sformatf("p_o vec%0d", i),   P_O,   tbl[i].exp_po);
      check($sformatf("ddr_o vec%0d", i), DDR_O, tbl[i].exp_ddr);
    end

    // Timer 0, P=64, V=2, IRQ enabled: underflow 129 edges after the load
    bus(1,1,0,7'h42,8'd2,8'h00);            // E0: counter = 128
    bus(1,1,0,7'h44,8'h01,8'h00);           // E1
    chk_irq("t64 irq after load", 1'b1);
    bus(1,1,1,7'h45,8'h00,8'h01);           // E2: 127 >> 6
    bus(1,1,1,7'h44,8'h00,8'h01);           // E3: control readback
    idle(125);                              // E4..E128
    chk_irq("t64 irq at 128", 1'b1);
    idle(1);                                // E129
    chk_irq("t64 irq at 129", 1'b0);
    bus(1,1,1,7'h45,8'h00,8'hFF);           // one-shot count read
    chk_irq("t64 irq after read", 1'b1);
    bus(1,1,1,7'h45,8'h00,8'hFE);

    // Timer 0 auto-reload, P=1, V=3: flag every 4 edges
    bus(1,1,0,7'h44,8'h03,8'h00);
    bus(1,1,0,7'h40,8'd3,8'h00);            // F0
    idle(3);
    chk_irq("ar irq F3", 1'b1);
    idle(1);
    chk_irq("ar irq F4", 1'b0);
    bus(1,1,1,7'h45,8'h00,8'h03);           // F5
    chk_irq("ar irq F5 cleared", 1'b1);
    idle(3);
    chk_irq("ar irq F8", 1'b0);
    bus(1,1,1,7'h45,8'h00,8'h03);           // F9
    idle(2);
    bus(1,1,0,7'h40,8'd3,8'h00);            // F12: write on underflow edge
    chk_irq("ar write beats underflow", 1'b1);
    idle(3);
    chk_irq("ar irq F15", 1'b1);
    idle(1);
    chk_irq("ar irq F16", 1'b0);
    bus(1,1,1,7'h45,8'h00,8'h03);           // F17
    idle(2);
    bus(1,1,1,7'h45,8'h00,8'h00);           // F20: read on underflow edge
    chk_irq("ar set beats read clear", 1'b0);
    bus(1,1,0,7'h44,8'h00,8'h00);
    bus(1,1,0,7'h43,8'hFF,8'h00);           // long count, flag cleared
    chk_irq("quiet timer", 1'b1);

    // Edge detect: port1 rising, port0 falling
    bus(1,1,0,7'h61,8'h03,8'h00);
    P_I = 16'hDA3C;
    idle(1);
    chk_irq("edge1 rise irq", 1'b0);
    bus(1,1,1,7'h7F,8'h00,8'h02);
    chk_irq("edge1 cleared", 1'b1);
    bus(1,1,1,7'h61,8'h00,8'h03);
    P_I = 16'h5A3C;
    idle(1);
    chk_irq("edge1 fall no irq", 1'b1);
    bus(1,1,1,7'h7F,8'h00,8'h00);
    bus(1,1,0,7'h60,8'h01,8'h00);
    P_I = 16'h5ABC;
    idle(1);
    chk_irq("edge0 rise no irq", 1'b1);
    P_I = 16'h5A3C;
    idle(1);
    chk_irq("edge0 fall irq", 1'b0);
    bus(1,1,1,7'h7F,8'h00,8'h01);
    chk_irq("edge0 cleared", 1'b1);

    // Asynchronous reset with IRQ asserted and non-zero outputs
    bus(1,1,0,7'h44,8'h01,8'h00);
    bus(1,1,0,7'h40,8'h00,8'h00);           // counter 0
    bus(1,0,1,7'h05,8'h00,8'hA5);           // underflow on this edge
    chk_irq("pre-reset irq", 1'b0);
    #1 RES_N = 1'b0;
    #1;
    chk_irq("async rst irq_n", 1'b1);
    check("async rst p_o",   P_O,   16'h0000);
    check("async rst ddr_o", DDR_O, 16'h0000);
    check("async rst d_o",   {8'h00, bif.D_O}, 16'h0000);
    @(negedge PHI2); #1;
    RES_N = 1'b1;
    bus(1,0,1,7'h05,8'h00,8'hA5);           // RAM survives reset
    bus(1,1,1,7'h7F,8'h00,8'h10);
    bus(1,1,1,7'h61,8'h00,8'h00);
    bus(1,1,1,7'h44,8'h00,8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
